// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_pkg: shared FSM state type and default operand width
package serial_add_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: start/operand request and registered result bundle
interface serial_add_ctrl_if import serial_add_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic start, cin, sub, busy, done, cout, ovf;
  logic [WIDTH-1:0] op_a, op_b, sum;
  modport master(output start, op_a, op_b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave(input start, op_a, op_b, cin, sub, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_add_ctrl_full_adder.sv
// FullAdder: one-bit full adder
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract, one result bit per clock
module serial_add_ctrl import serial_add_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
  input logic clk,
  input logic rst,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t state, nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res;
  logic [CW-1:0] cnt;
  logic carry, fa_s, fa_c, last;
  assign last = cnt == CW'(WIDTH - 1);
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  FullAdder fa (.a(a_sr[0]), .b(b_sr[0]), .c(carry), .sum(fa_s), .carry(fa_c));
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next state: accept only from IDLE, finish after the last bit, DONE lasts one cycle
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (bus.start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  // datapath: subtract is A + ~B + 1, so invert B and force the carry-in on load
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      res <= '0;
      carry <= 1'b0;
      cnt <= '0;
      bus.sum <= '0;
      bus.cout <= 1'b0;
      bus.ovf <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      a_sr <= bus.op_a;
      b_sr <= bus.sub ? ~bus.op_b : bus.op_b;
      carry <= bus.cin | bus.sub;
      cnt <= '0;
    end else if (state == RUN) begin
      res <= {fa_s, res[WIDTH-1:1]};
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      carry <= fa_c;
      cnt <= last ? '0 : cnt + CW'(1);
      if (last) begin
        bus.sum <= {fa_s, res[WIDTH-1:1]};
        bus.cout <= fa_c;
        bus.ovf <= carry ^ fa_c;
      end
    end
endmodule
